// File: rtl/memctrl_ext.sv
// memctrl_ext: CPU-side memory/IO controller for the AVR board top level.
// Decodes the CPU byte bus into an IO register block, a text video window,
// a banked graphics window and SRAM. Adds a PS/2 scancode FIFO and a polled
// SDRAM transaction engine with a per-phase timeout.
module memctrl_ext #(
    parameter logic [15:0] IO_BASE     = 16'h0020,
    parameter logic [15:0] TEXT_BASE   = 16'hD000,
    parameter logic [15:0] GRPH_BASE   = 16'hE000,
    parameter int          GRPH_BANK_W = 5,
    parameter int          KBD_DEPTH   = 16,
    parameter int          SDRAM_AW    = 26,
    parameter int          TIMEOUT     = 1023
) (
    input  logic                      clock,
    input  logic                      reset_n,
    // CPU byte bus
    input  logic [15:0]               address,
    input  logic                      wren,
    input  logic                      rden,
    input  logic [7:0]                data_o,
    output logic [7:0]                data_i,
    // memories
    input  logic [7:0]                data_o_sram,
    input  logic [7:0]                data_o_text,
    input  logic [7:0]                data_o_grph,
    output logic                      data_w_sram,
    output logic                      data_w_text,
    output logic                      data_w_grph,
    output logic [12:0]               text_addr,
    output logic [GRPH_BANK_W+11:0]   grph_addr,
    // video IO registers
    output logic [7:0]                bank,
    output logic [7:0]                videomode,
    output logic [7:0]                cursor_x,
    output logic [7:0]                cursor_y,
    // keyboard
    input  logic [7:0]                ps2_data,
    input  logic                      ps2_hit,
    // SDRAM
    output logic [SDRAM_AW-1:0]       sdram_address,
    output logic [7:0]                sdram_i_data,
    output logic                      sdram_we,
    output logic                      sdram_req,
    input  logic [7:0]                sdram_o_data,
    input  logic                      sdram_ready
);

    localparam int KPW = $clog2(KBD_DEPTH);
    localparam int KCW = KPW + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    // IO register offsets within the 16-byte block
    localparam logic [3:0] OFF_BANK  = 4'd0;
    localparam logic [3:0] OFF_VMODE = 4'd1;
    localparam logic [3:0] OFF_CURX  = 4'd2;
    localparam logic [3:0] OFF_CURY  = 4'd3;
    localparam logic [3:0] OFF_KDATA = 4'd4;
    localparam logic [3:0] OFF_KSTAT = 4'd5;
    localparam logic [3:0] OFF_SA0   = 4'd6;
    localparam logic [3:0] OFF_SA1   = 4'd7;
    localparam logic [3:0] OFF_SA2   = 4'd8;
    localparam logic [3:0] OFF_SA3   = 4'd9;
    localparam logic [3:0] OFF_SDATA = 4'd10;
    localparam logic [3:0] OFF_SCTL  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_DONE_WAIT
    } sd_state_e;

    // ------------------------------------------------------------------
    // Address decode: IO block wins over TEXT, TEXT over GRPH, rest is SRAM
    // ------------------------------------------------------------------
    logic       io_hit, text_hit, grph_hit, sram_hit;
    logic [3:0] io_off;
    logic       io_wr, io_rd;

    assign io_hit   = (address[15:4] == IO_BASE[15:4]);
    assign text_hit = !io_hit && (address[15:12] == TEXT_BASE[15:12]);
    assign grph_hit = !io_hit && !text_hit && (address[15:12] == GRPH_BASE[15:12]);
    assign sram_hit = !io_hit && !text_hit && !grph_hit;
    assign io_off   = address[3:0];
    assign io_wr    = wren && io_hit;
    assign io_rd    = rden && io_hit;

    assign data_w_sram = wren && sram_hit;
    assign data_w_text = wren && text_hit;
    assign data_w_grph = wren && grph_hit;

    // ------------------------------------------------------------------
    // Video IO registers
    // ------------------------------------------------------------------
    logic [7:0] bank_q, vmode_q, curx_q, cury_q;

    assign bank      = bank_q;
    assign videomode = vmode_q;
    assign cursor_x  = curx_q;
    assign cursor_y  = cury_q;
    assign text_addr = {bank_q[0], address[11:0]};
    assign grph_addr = {bank_q[GRPH_BANK_W-1:0], address[11:0]};

    // Video register writes from the CPU
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_q  <= '0;
            vmode_q <= '0;
            curx_q  <= '0;
            cury_q  <= '0;
        end else if (io_wr) begin
            case (io_off)
                OFF_BANK:  bank_q  <= data_o;
                OFF_VMODE: vmode_q <= data_o;
                OFF_CURX:  curx_q  <= data_o;
                OFF_CURY:  cury_q  <= data_o;
                default:   ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Keyboard FIFO
    // ------------------------------------------------------------------
    logic [7:0]     kbd_mem [KBD_DEPTH];
    logic [KPW-1:0] kbd_wr_ptr_q, kbd_rd_ptr_q;
    logic [KCW-1:0] kbd_cnt_q;
    logic           ps2_hit_q;
    logic           kbd_ovf_q;
    logic           kbd_empty, kbd_full;
    logic           kbd_push_req, kbd_push, kbd_pop, kbd_drop;

    assign kbd_empty    = (kbd_cnt_q == '0);
    assign kbd_full     = (kbd_cnt_q == KCW'(KBD_DEPTH));
    assign kbd_push_req = ps2_hit && !ps2_hit_q;
    assign kbd_pop      = io_rd && (io_off == OFF_KDATA) && !kbd_empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign kbd_push     = kbd_push_req && (!kbd_full || kbd_pop);
    assign kbd_drop     = kbd_push_req && kbd_full && !kbd_pop;

    // FIFO storage
    // NOTE: the data array has no reset; occupancy is tracked by the reset pointers and count.
    always_ff @(posedge clock) begin
        if (kbd_push) begin
            kbd_mem[kbd_wr_ptr_q] <= ps2_data;
        end
    end

    // Edge detector, pointers, occupancy and sticky overflow flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ps2_hit_q    <= 1'b0;
            kbd_wr_ptr_q <= '0;
            kbd_rd_ptr_q <= '0;
            kbd_cnt_q    <= '0;
            kbd_ovf_q    <= 1'b0;
        end else begin
            ps2_hit_q <= ps2_hit;
            if (kbd_push) begin
                kbd_wr_ptr_q <= kbd_wr_ptr_q + KPW'(1);
            end
            if (kbd_pop) begin
                kbd_rd_ptr_q <= kbd_rd_ptr_q + KPW'(1);
            end
            case ({kbd_push, kbd_pop})
                2'b10:   kbd_cnt_q <= kbd_cnt_q + KCW'(1);
                2'b01:   kbd_cnt_q <= kbd_cnt_q - KCW'(1);
                default: ;
            endcase
            // A fresh overflow takes precedence over a clear in the same cycle.
            if (kbd_drop) begin
                kbd_ovf_q <= 1'b1;
            end else if (io_wr && (io_off == OFF_KSTAT)) begin
                kbd_ovf_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // SDRAM transaction engine
    // ------------------------------------------------------------------
    sd_state_e   sd_state_q, sd_state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        op_wr_q, op_wr_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [31:0] saddr_q;
    logic [7:0]  sdata_q;
    logic        busy;
    logic        start_wr, start_rd;

    assign busy     = (sd_state_q != S_IDLE);
    assign start_wr = io_wr && (io_off == OFF_SDATA);
    assign start_rd = io_wr && (io_off == OFF_SCTL) && data_o[0];

    assign sdram_req     = (sd_state_q == S_ACCEPT);
    assign sdram_we      = (sd_state_q == S_ACCEPT) && op_wr_q;
    assign sdram_address = saddr_q[SDRAM_AW-1:0];
    assign sdram_i_data  = sdata_q;

    // Address and write-data registers; frozen while a transaction is in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saddr_q <= '0;
            sdata_q <= '0;
        end else if (io_wr && !busy) begin
            case (io_off)
                OFF_SA0:   saddr_q[7:0]   <= data_o;
                OFF_SA1:   saddr_q[15:8]  <= data_o;
                OFF_SA2:   saddr_q[23:16] <= data_o;
                OFF_SA3:   saddr_q[31:24] <= data_o;
                OFF_SDATA: sdata_q        <= data_o;
                default:   ;
            endcase
        end
    end

    // SDRAM FSM state and bookkeeping registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sd_state_q <= S_IDLE;
            tmo_q      <= '0;
            op_wr_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            sd_state_q <= sd_state_d;
            tmo_q      <= tmo_d;
            op_wr_q    <= op_wr_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // SDRAM FSM next state: handshake on sdram_ready with a per-phase timeout
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        sd_state_d = sd_state_q;
        tmo_d      = tmo_q;
        op_wr_d    = op_wr_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (sd_state_q)
            S_IDLE: begin
                if (start_wr || start_rd) begin
                    sd_state_d = S_ACCEPT;
                    tmo_d      = '0;
                    op_wr_d    = start_wr;
                    err_d      = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (!sdram_ready) begin
                    sd_state_d = S_DONE_WAIT;
                    tmo_d      = '0;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    sd_state_d = S_IDLE;
                    tmo_d      = '0;
                    err_d      = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE_WAIT: begin
                if (sdram_ready) begin
                    sd_state_d = S_IDLE;
                    tmo_d      = '0;
                    if (!op_wr_q) begin
                        rdata_d = sdram_o_data;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    sd_state_d = S_IDLE;
                    tmo_d      = '0;
                    err_d      = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: sd_state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // CPU read data: purely combinational so the memories set the latency
    // ------------------------------------------------------------------
    logic [7:0] io_rdata;
    logic [7:0] kbd_head;

    assign kbd_head = kbd_empty ? 8'h00 : kbd_mem[kbd_rd_ptr_q];

    // IO register read mux
    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            OFF_BANK:  io_rdata = bank_q;
            OFF_VMODE: io_rdata = vmode_q;
            OFF_CURX:  io_rdata = curx_q;
            OFF_CURY:  io_rdata = cury_q;
            OFF_KDATA: io_rdata = kbd_head;
            OFF_KSTAT: io_rdata = {5'b0, err_q, kbd_ovf_q, !kbd_empty};
            OFF_SA0:   io_rdata = saddr_q[7:0];
            OFF_SA1:   io_rdata = saddr_q[15:8];
            OFF_SA2:   io_rdata = saddr_q[23:16];
            OFF_SA3:   io_rdata = saddr_q[31:24];
            OFF_SDATA: io_rdata = rdata_q;
            OFF_SCTL:  io_rdata = {7'b0, busy};
            default:   io_rdata = 8'h00;
        endcase
    end

    // Region read mux
    always_comb begin
        data_i = data_o_sram;
        if (io_hit) begin
            data_i = io_rdata;
        end else if (text_hit) begin
            data_i = data_o_text;
        end else if (grph_hit) begin
            data_i = data_o_grph;
        end
    end

endmodule
